n_mem_streamer: RTL
===================

// Module: n_mem_streamer
// PURPOSE
//  Read sequencer for the modulus ROM (n_mem). On start, walks word_count N-words from base_addr, absorbs the
//  ROM's fixed registered-read latency and presents words as a valid/ready stream to the Montgomery datapath.
//  ROM output cannot stall, so a small credit-controlled FIFO absorbs downstream backpressure.
//  No word is lost or duplicated.
// PARAMETERS
//  ADDR_WIDTH   `ADDR_WIDTH  ROM address width
//  DATA_WIDTH   `DATA_WIDTH  ROM word width
//  TOTAL_ADDR   `TOTAL_ADDR  ROM depth in words; addresses wrap at this value
//  RD_LATENCY   2            cycles from mem_address to valid mem_q (address reg + output reg)
//  FIFO_DEPTH   4            output buffer entries; must be >= RD_LATENCY+1
// PORTS
//  clock        in   1               rising-edge clock, shared with n_mem
//  reset_n      in   1               asynchronous active-low reset
//  start        in   1               1-cycle request; sampled only in IDLE
//  base_addr    in   ADDR_WIDTH      first word address, latched on start
//  word_count   in   ADDR_WIDTH+1    words to stream (0..TOTAL_ADDR), latched on start
//  mem_address  out  ADDR_WIDTH      to n_mem.address
//  mem_q        in   DATA_WIDTH      from n_mem.q
//  out_data     out  DATA_WIDTH      head-of-FIFO word
//  out_valid    out  1               out_data valid
//  out_ready    in   1               consumer accepts when out_valid&out_ready
//  out_last     out  1               qualifies final word of the request
//  busy         out  1               high from accepted start until done
//  done         out  1               1-cycle pulse, request complete
// BEHAVIOUR
//  Reset (async, any state): FSM->IDLE; FIFO, in-flight pipe, counters cleared.
//   Outputs: mem_address=0, out_valid=0, out_last=0, busy=0, done=0, out_data=0.
//  FSM: IDLE -start-> ISSUE (word_count>0) or DONE (word_count==0).
//   ISSUE -> DRAIN after last address issued.
//   DRAIN -> DONE on handshake of the out_last word. DONE -> IDLE (one cycle, done=1).
//  busy=1 in ISSUE/DRAIN/DONE. start outside IDLE is ignored (no relatch).
//  mem_address is a register: base_addr loaded on start; increments after each issue.
//   TOTAL_ADDR-1 wraps to 0. It holds its value when not issuing.
//  Issue rule: a read is issued in a cycle iff state==ISSUE, issued<word_count,
//   and fifo_count+inflight < FIFO_DEPTH. No read is issued otherwise.
//  In-flight pipe: RD_LATENCY-deep valid/last shift register.
//   When it emerges, mem_q is written into the FIFO that same cycle.
//  FIFO write and read allowed in the same cycle; count unchanged.
//   Overflow is impossible by the credit rule (assertion).
//  out_last is carried through pipe and FIFO with the final issued word.
//  Latency: start high in cycle T -> mem_address=base in T+1 -> mem_q valid T+3 -> out_valid in T+4.
//  Throughput: 1 word/cycle while out_ready=1.
//  done asserts the cycle after the out_last handshake; word_count==0 gives done at T+1 with no out_valid.
// TESTING
//  base=0,count=TOTAL_ADDR,ready=1 -> words == nMem.mif order; first out_valid at T+4; out_last on word TOTAL_ADDR; done next cycle.
//  Same, out_ready low 20 cycles mid-stream then random -> identical word sequence; fifo_count+inflight never >4.
//  base=TOTAL_ADDR-2,count=4 -> mem_address 126,127,0,1 (TOTAL_ADDR=128); 4 words, last flagged.
//  count=0 -> done pulse at T+1, busy for 1 cycle, out_valid never high.
//  reset_n low during DRAIN with 2 words buffered -> outputs 0 immediately; new start after release streams cleanly.
//  start pulsed while busy with different base -> ignored; original stream completes unchanged.

Source files
------------

// File: rtl/n_mem_streamer.sv
// Read sequencer for the modulus ROM: issues a run of reads, hides the ROM read latency and
// presents the words as a valid/ready stream, buffering backpressure in a credit-limited FIFO.
module n_mem_streamer #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32,
    parameter int TOTAL_ADDR = 128,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_WIDTH-1:0]   r_mem_address;
    logic [ADDR_WIDTH:0]     r_req_count;
    logic [ADDR_WIDTH:0]     r_issued;
    logic [RD_LATENCY-1:0]   r_pipe_v;
    logic [RD_LATENCY-1:0]   r_pipe_last;
    logic [DATA_WIDTH-1:0]   r_fifo_data [FIFO_DEPTH];
    logic                    r_fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_fifo_cnt;

    logic [CNT_W-1:0]        w_inflight;
    logic                    w_credit;
    logic                    w_issue;
    logic                    w_issue_last;
    logic                    w_wr;
    logic                    w_rd;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_inflight = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + CNT_W'(r_pipe_v[i]);
        end
    end

    // Credits cover words already buffered plus reads still inside the ROM, since those cannot stall.
    assign w_credit     = (r_fifo_cnt + w_inflight) < CNT_W'(FIFO_DEPTH);
    assign w_issue      = (r_state == S_ISSUE) && (r_issued < r_req_count) && w_credit;
    assign w_issue_last = w_issue && ((r_issued + CNT_ONE) == r_req_count);
    assign w_wr         = r_pipe_v[RD_LATENCY-1];
    assign w_rd         = out_valid && out_ready;

    assign mem_address = r_mem_address;
    assign out_valid   = (r_fifo_cnt != '0);
    assign out_data    = out_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign out_last    = out_valid && r_fifo_last[r_rd_ptr];

    always_comb begin
        w_next = r_state;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = (word_count == '0) ? S_DONE : S_ISSUE;
            end
            S_ISSUE: if (w_issue_last) w_next = S_DRAIN;
            S_DRAIN: if (w_rd && out_last) w_next = S_DONE;
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_mem_address <= '0;
            r_req_count   <= '0;
            r_issued      <= '0;
            r_pipe_v      <= '0;
            r_pipe_last   <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_fifo_cnt    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                r_mem_address <= base_addr;
                r_req_count   <= word_count;
                r_issued      <= '0;
            end else if (w_issue) begin
                r_mem_address <= (r_mem_address == ADDR_WIDTH'(TOTAL_ADDR - 1)) ? '0
                                                                                : r_mem_address + 1'b1;
                r_issued      <= r_issued + CNT_ONE;
            end
            r_pipe_v[0]    <= w_issue;
            r_pipe_last[0] <= w_issue_last;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                r_pipe_v[i]    <= r_pipe_v[i-1];
                r_pipe_last[i] <= r_pipe_last[i-1];
            end
            if (w_wr) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_rd) r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_wr, w_rd})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_fifo_data[r_wr_ptr] <= mem_q;
            r_fifo_last[r_wr_ptr] <= r_pipe_last[RD_LATENCY-1];
        end
    end

    assert property (@(posedge clock) disable iff (!reset_n)
        !(w_wr && !w_rd && r_fifo_cnt == CNT_W'(FIFO_DEPTH)));

endmodule
